// File: rtl/dp_mem_bank_pipe_if.sv
// Request/response bundle for the dual-port banked memory: port A and port B
// request fields, their read-return strobes and data, and the collision pulse.
interface dp_mem_bank_pipe_if #(
    parameter int DataWidth = 128,
    parameter int AddrWidth = 12
);
    localparam int NumCol = DataWidth / 8;

    logic                 reqA;
    logic [NumCol-1:0]    weA;
    logic [AddrWidth-1:0] addrA;
    logic [DataWidth-1:0] dinA;
    logic                 rvalidA;
    logic [DataWidth-1:0] doutA;

    logic                 reqB;
    logic [NumCol-1:0]    weB;
    logic [AddrWidth-1:0] addrB;
    logic [DataWidth-1:0] dinB;
    logic                 rvalidB;
    logic [DataWidth-1:0] doutB;

    logic                 collision;

    modport master (
        output reqA, weA, addrA, dinA,
        output reqB, weB, addrB, dinB,
        input  rvalidA, doutA, rvalidB, doutB, collision
    );

    modport slave (
        input  reqA, weA, addrA, dinA,
        input  reqB, weB, addrB, dinB,
        output rvalidA, doutA, rvalidB, doutB, collision
    );
endinterface

// File: rtl/dp_mem_bank_pipe.sv
// True dual-port banked SRAM built from 32-bit byte-write columns, with a
// registered per-port bank mux, optional output stage and collision detection.
module dp_mem_bank_pipe #(
    parameter int SizeKiB   = 64,
    parameter int DataWidth = 128,
    parameter int BankDepth = 1024,
    parameter int OutReg    = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dp_mem_bank_pipe_if.slave bus
);
    localparam int NumCol    = DataWidth / 8;
    localparam int NumBanks  = SizeKiB * 1024 / (NumCol * BankDepth);
    localparam int AddrWidth = $clog2(SizeKiB * 1024 / NumCol);
    localparam int WordBits  = $clog2(BankDepth);
    localparam int BankBits  = (NumBanks > 1) ? $clog2(NumBanks) : 1;
    localparam int NumRamCol = DataWidth / 32;

    logic [1:0]                              portReq;
    logic [1:0]                              portWr;
    logic [1:0][NumCol-1:0]                  portWe;
    logic [1:0][DataWidth-1:0]               portDin;
    logic [1:0][AddrWidth-1:0]               portAddr;
    logic [1:0][WordBits-1:0]                portWord;
    logic [1:0][BankBits-1:0]                portBank;
    logic [1:0][NumBanks-1:0]                bankEn;
    logic [1:0][NumBanks-1:0][DataWidth-1:0] bankQ;
    logic [1:0]                              portRvalid;
    logic [1:0][DataWidth-1:0]               portDout;
    logic                                    collisionQ;

    // Index 0 is port A, index 1 is port B throughout.
    assign portReq  = {bus.reqB, bus.reqA};
    assign portWe   = {bus.weB, bus.weA};
    assign portDin  = {bus.dinB, bus.dinA};
    assign portAddr = {bus.addrB, bus.addrA};

    for (genvar p = 0; p < 2; p++) begin : gPortDecode
        assign portWr[p]   = |portWe[p];
        assign portWord[p] = portAddr[p][WordBits-1:0];
        if (NumBanks > 1) begin : gBankField
            assign portBank[p] = portAddr[p][AddrWidth-1:WordBits];
        end else begin : gNoBankField
            assign portBank[p] = '0;
        end
    end

    always_comb begin
        bankEn = '0;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NumBanks; b++) begin
                if (portReq[p] && (portBank[p] == BankBits'(b))) begin
                    bankEn[p][b] = 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : gBank
        for (genvar c = 0; c < NumRamCol; c++) begin : gCol
            logic [31:0]         mem [BankDepth];
            logic [31:0]         qA;
            logic [31:0]         qB;
            logic                enA;
            logic                enB;
            logic [3:0]          laneA;
            logic [3:0]          laneB;
            logic [31:0]         dataA;
            logic [31:0]         dataB;
            logic [WordBits-1:0] wordA;
            logic [WordBits-1:0] wordB;

            assign enA   = bankEn[0][b];
            assign enB   = bankEn[1][b];
            assign laneA = portWe[0][c*4 +: 4];
            assign laneB = portWe[1][c*4 +: 4];
            assign dataA = portDin[0][c*32 +: 32];
            assign dataB = portDin[1][c*32 +: 32];
            assign wordA = portWord[0];
            assign wordB = portWord[1];

            // Reads sample the pre-edge contents; B's lanes are assigned before
            // A's so that A wins any lane both ports write to the same word.
            always_ff @(posedge clk_i) begin
                if (enA && !portWr[0]) qA <= mem[wordA];
                if (enB && !portWr[1]) qB <= mem[wordB];
                if (enB) begin
                    if (laneB[0]) mem[wordB][7:0]   <= dataB[7:0];
                    if (laneB[1]) mem[wordB][15:8]  <= dataB[15:8];
                    if (laneB[2]) mem[wordB][23:16] <= dataB[23:16];
                    if (laneB[3]) mem[wordB][31:24] <= dataB[31:24];
                end
                if (enA) begin
                    if (laneA[0]) mem[wordA][7:0]   <= dataA[7:0];
                    if (laneA[1]) mem[wordA][15:8]  <= dataA[15:8];
                    if (laneA[2]) mem[wordA][23:16] <= dataA[23:16];
                    if (laneA[3]) mem[wordA][31:24] <= dataA[31:24];
                end
            end

            assign bankQ[0][b][c*32 +: 32] = qA;
            assign bankQ[1][b][c*32 +: 32] = qB;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : gPortPipe
        logic                 vld0;
        logic                 vld1;
        logic [BankBits-1:0]  sel0;
        logic [DataWidth-1:0] muxQ;
        logic [DataWidth-1:0] data1;

        if (NumBanks > 1) begin : gMux
            assign muxQ = bankQ[p][sel0];
        end else begin : gNoMux
            assign muxQ = bankQ[p][0];
        end

        // The bank select rides alongside the RAM read so the mux never sees
        // the live address; data registers only load on a completing read.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld0  <= 1'b0;
                sel0  <= '0;
                vld1  <= 1'b0;
                data1 <= '0;
            end else begin
                vld0 <= portReq[p] && !portWr[p];
                if (portReq[p] && !portWr[p]) sel0 <= portBank[p];
                vld1 <= vld0;
                if (vld0) data1 <= muxQ;
            end
        end

        if (OutReg != 0) begin : gOutReg
            logic                 vld2;
            logic [DataWidth-1:0] data2;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld2  <= 1'b0;
                    data2 <= '0;
                end else begin
                    vld2 <= vld1;
                    if (vld1) data2 <= data1;
                end
            end

            assign portRvalid[p] = vld2;
            assign portDout[p]   = data2;
        end else begin : gNoOutReg
            assign portRvalid[p] = vld1;
            assign portDout[p]   = data1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            collisionQ <= 1'b0;
        end else begin
            collisionQ <= bus.reqA && bus.reqB && (bus.addrA == bus.addrB);
        end
    end

    assign bus.rvalidA   = portRvalid[0];
    assign bus.doutA     = portDout[0];
    assign bus.rvalidB   = portRvalid[1];
    assign bus.doutB     = portDout[1];
    assign bus.collision = collisionQ;
endmodule

// File: tb/tb_dp_mem_bank_pipe.sv
// Scoreboard bench for dp_mem_bank_pipe: one instance without and one with the
// output register, driven identically; a negedge monitor checks every return.
module tb_dp_mem_bank_pipe;
    localparam int DataWidth = 128;
    localparam int AddrWidth = 12;
    localparam int NumCol    = 16;
    localparam logic [95:0] Hi = 96'h0123_4567_89AB_CDEF_F0E1_D2C3;

    typedef struct packed {
        logic                 req;
        logic [NumCol-1:0]    we;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] din;
        logic [DataWidth-1:0] exp;
    } opT;

    typedef struct {
        logic [DataWidth-1:0] data;
        int                   issue;
    } expT;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   passes = 0;
    expT  sb [4][$];
    bit   collExp [int];
    expT  monE;
    string sbName [4] = '{"dut0.A", "dut0.B", "dut1.A", "dut1.B"};

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    dp_mem_bank_pipe_if #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) bus0 ();
    dp_mem_bank_pipe_if #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) bus1 ();

    dp_mem_bank_pipe #(.SizeKiB(64), .DataWidth(DataWidth), .BankDepth(1024), .OutReg(0)) dut0 (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus0)
    );

    dp_mem_bank_pipe #(.SizeKiB(64), .DataWidth(DataWidth), .BankDepth(1024), .OutReg(1)) dut1 (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus1)
    );

    logic [3:0]           mRvalid;
    logic [DataWidth-1:0] mDout [4];
    assign mRvalid  = {bus1.rvalidB, bus1.rvalidA, bus0.rvalidB, bus0.rvalidA};
    assign mDout[0] = bus0.doutA;
    assign mDout[1] = bus0.doutB;
    assign mDout[2] = bus1.doutA;
    assign mDout[3] = bus1.doutB;

    function automatic opT nop();
        nop = '0;
    endfunction

    function automatic opT rd(input logic [AddrWidth-1:0] a, input logic [DataWidth-1:0] e);
        rd      = '0;
        rd.req  = 1'b1;
        rd.addr = a;
        rd.exp  = e;
    endfunction

    function automatic opT wr(input logic [AddrWidth-1:0] a, input logic [NumCol-1:0] w,
                              input logic [DataWidth-1:0] d);
        wr      = '0;
        wr.req  = 1'b1;
        wr.we   = w;
        wr.addr = a;
        wr.din  = d;
    endfunction

    task automatic checkOutput(input string name, input logic [DataWidth-1:0] actual,
                               input logic [DataWidth-1:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic pushRead(input int idx, input logic [DataWidth-1:0] data);
        expT e;
        e.data  = data;
        e.issue = cycle + 1;
        sb[idx].push_back(e);
    endtask

    task automatic driveOps(input opT a, input opT b);
        bus0.reqA = a.req; bus0.weA = a.we; bus0.addrA = a.addr; bus0.dinA = a.din;
        bus0.reqB = b.req; bus0.weB = b.we; bus0.addrB = b.addr; bus0.dinB = b.din;
        bus1.reqA = a.req; bus1.weA = a.we; bus1.addrA = a.addr; bus1.dinA = a.din;
        bus1.reqB = b.req; bus1.weB = b.we; bus1.addrB = b.addr; bus1.dinB = b.din;
        if (a.req && a.we == '0) begin
            pushRead(0, a.exp);
            pushRead(2, a.exp);
        end
        if (b.req && b.we == '0) begin
            pushRead(1, b.exp);
            pushRead(3, b.exp);
        end
        collExp[cycle + 1] = a.req && b.req && (a.addr == b.addr);
    endtask

    task automatic applyStimulus(input opT a, input opT b);
        @(negedge clk);
        driveOps(a, b);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(nop(), nop());
    endtask

    task automatic checkZeros(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, " ", sbName[i], ".rvalid"}, DataWidth'(mRvalid[i]), '0);
            checkOutput({tag, " ", sbName[i], ".dout"}, mDout[i], '0);
        end
        checkOutput({tag, " dut0.collision"}, DataWidth'(bus0.collision), '0);
        checkOutput({tag, " dut1.collision"}, DataWidth'(bus1.collision), '0);
    endtask

    // Pops the oldest expected read whenever a port presents rvalid, and checks
    // the collision pulse against the request sampled at the preceding edge.
    always @(negedge clk) begin
        if (rstN) begin
            for (int i = 0; i < 4; i++) begin
                if (mRvalid[i]) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        $display("[TB] FAIL %s.unexpected_rvalid: got 1, expected 0", sbName[i]);
                    end else begin
                        monE = sb[i].pop_front();
                        checkOutput({sbName[i], ".data"}, mDout[i], monE.data);
                        checkOutput({sbName[i], ".latency"}, DataWidth'(cycle - monE.issue),
                                    DataWidth'((i < 2) ? 1 : 2));
                    end
                end
            end
            checkOutput("dut0.collision", DataWidth'(bus0.collision),
                        DataWidth'(collExp.exists(cycle) ? collExp[cycle] : 1'b0));
            checkOutput("dut1.collision", DataWidth'(bus1.collision),
                        DataWidth'(collExp.exists(cycle) ? collExp[cycle] : 1'b0));
        end
    end

    initial begin
        driveOps(nop(), nop());
        rstN = 1'b0;
        #12;
        checkZeros("reset");
        @(negedge clk);
        rstN = 1'b1;

        // Bank sweep: one word at each bank edge, plus bank 2 for the cross-bank run.
        applyStimulus(wr(12'h000, 16'hFFFF, {Hi, 32'h0000_0000}), nop());
        applyStimulus(wr(12'h3FF, 16'hFFFF, {Hi, 32'h0000_03FF}), nop());
        applyStimulus(wr(12'h400, 16'hFFFF, {Hi, 32'h0001_0000}), nop());
        applyStimulus(wr(12'hFFF, 16'hFFFF, {Hi, 32'h0003_03FF}), nop());
        applyStimulus(wr(12'h800, 16'hFFFF, {Hi, 32'h0002_0000}), nop());
        applyStimulus(nop(), rd(12'h000, {Hi, 32'h0000_0000}));
        applyStimulus(nop(), rd(12'h3FF, {Hi, 32'h0000_03FF}));
        applyStimulus(nop(), rd(12'h400, {Hi, 32'h0001_0000}));
        applyStimulus(nop(), rd(12'hFFF, {Hi, 32'h0003_03FF}));

        // Back-to-back reads crossing banks on port A.
        applyStimulus(rd(12'h3FF, {Hi, 32'h0000_03FF}), nop());
        applyStimulus(rd(12'h400, {Hi, 32'h0001_0000}), nop());
        applyStimulus(rd(12'h800, {Hi, 32'h0002_0000}), nop());
        idle(3);

        // Byte enables: clear bytes 4..7 of an all-ones word, read on the other port.
        applyStimulus(wr(12'h010, 16'hFFFF, {128{1'b1}}), nop());
        applyStimulus(wr(12'h010, 16'h00F0, '0), nop());
        applyStimulus(nop(), rd(12'h010, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF));

        // Write-write collision, then both ports read the same word.
        applyStimulus(wr(12'h123, 16'h00FF, {16{8'hAA}}), wr(12'h123, 16'hFFFF, {16{8'hBB}}));
        applyStimulus(rd(12'h123, {{8{8'hBB}}, {8{8'hAA}}}), rd(12'h123, {{8{8'hBB}}, {8{8'hAA}}}));

        // Read-write collision returns old data; next-cycle read sees the new word.
        applyStimulus(wr(12'h200, 16'hFFFF, {16{8'h11}}), nop());
        applyStimulus(rd(12'h200, {16{8'h11}}), wr(12'h200, 16'hFFFF, {16{8'h22}}));
        applyStimulus(rd(12'h200, {16{8'h22}}), nop());
        idle(4);

        // Reset lands while a read is in flight; nothing may return afterwards.
        applyStimulus(rd(12'h400, {Hi, 32'h0001_0000}), nop());
        @(posedge clk);
        #2;
        rstN = 1'b0;
        driveOps(nop(), nop());
        for (int i = 0; i < 4; i++) sb[i].delete();
        #1;
        checkZeros("mid-read reset");
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        idle(6);

        applyStimulus(nop(), rd(12'h3FF, {Hi, 32'h0000_03FF}));
        idle(5);
        #1;

        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sb[i].size() == 0) passes++;
            else $display("[TB] FAIL %s.pending_reads: got %0d, expected 0", sbName[i], sb[i].size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/dp_mem_bank_pipe.md
# dp_mem_bank_pipe

Single-clock, true dual-port banked SRAM array for core-side and DMA-side access. It generalises the existing dual-port bank in several ways: bank depth and output pipeline depth are parameters, read data comes with a valid strobe, and the bank select is registered so it stays aligned with read latency. Same-cycle port collisions are resolved deterministically. Each bank is built from 32-bit byte-write RAM columns of depth `BankDepth`; reads return through a registered per-port bank mux.

## Interface
- `SizeKiB`, 64, total capacity in KiB.
- `DataWidth`, 128, word width in bits; multiple of 32.
- `BankDepth`, 1024, words per bank; power of two.
- `OutReg`, 0, 0 or 1; adds one output register stage after the bank mux.
- `NumCol` (localparam), `DataWidth/8`, byte lanes per word.
- `NumBanks` (localparam), `SizeKiB*1024/(NumCol*BankDepth)`; must be a power of two ≥1.
- `AddrWidth` (localparam), `$clog2(SizeKiB*1024/NumCol)`, word address width.
- `clk_i`  in  1  single clock for both ports.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `reqA_i`  in  1  port A request.
- `weA_i`  in  NumCol  port A byte write enables; all-zero means read.
- `addrA_i`  in  AddrWidth  port A word address.
- `dinA_i`  in  DataWidth  port A write data.
- `rvalidA_o`  out  1  port A read data valid, one-cycle pulse.
- `doutA_o`  out  DataWidth  port A read data.
- `reqB_i`, `weB_i`, `addrB_i`, `dinB_i`, `rvalidB_o`, `doutB_o`: same as port A, for port B.
- `collision_o`  out  1  pulse: both ports requested the same address in the same cycle.

## Operation
- Address split: `addr[log2(BankDepth)-1:0]` selects the word in a bank; upper bits select the bank. When `NumBanks==1` there is no bank field.
- A port accepts a request every cycle when `req` is high. There is no backpressure.
- Only the addressed bank is enabled for a request; all other banks stay idle.
- Write (`we != 0`): byte lanes with `we[k]=1` are written. No read data and no `rvalid` are produced.
- Read (`we == 0`): returns the addressed word. The bank select and a valid bit travel down a pipeline with the same latency as the data, so the output mux never uses the live address.
- `dout` holds its last value until the next read completes on that port. It does not follow the bank mux between reads.
- Collision (`reqA & reqB & addrA==addrB`): `collision_o=1` for that cycle, registered, so it appears one cycle after the request.
  - Both ports write: port A wins on overlapping byte lanes. Port B lanes not written by A are written.
  - One port reads, the other writes: the read returns the old (pre-write) data.
  - Both ports read: both return the same data; `collision_o` still asserts.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Read latency is 1+`OutReg` cycles from the request edge to `rvalid`/`dout`.
  - `OutReg=0`: request at edge N, data valid after edge N+1.
  - `OutReg=1`: data valid after edge N+2.
- Throughput is one request per port per cycle. Back-to-back reads to different banks return in order with no bubbles.
- A write at edge N is visible to a read from either port issued at edge N+1 or later.
- Reset values: `rvalidA_o=0`, `rvalidB_o=0`, `doutA_o=0`, `doutB_o=0`, `collision_o=0`, registered bank selects = 0.
- Reset asserted mid-operation clears all valid and pipeline registers immediately. Reads in flight are dropped, with no `rvalid` after reset release. A write coinciding with reset assertion may or may not land.
- First request is accepted at the first rising edge after `rst_ni` deasserts.

## Test plan
Defaults for all scenarios: `AddrWidth=12`, `NumBanks=4`.
- **Bank sweep.** Write `0x…_0000_bank_word` to words 0x000, 0x3FF, 0x400, 0xFFF on port A, then read them back on port B, `OutReg=0` and `OutReg=1`.
  - Required: data matches.
  - Required: `rvalidB_o` rises exactly 1 or 2 cycles after each request.
- **Pipelined cross-bank reads.** Port A reads 0x3FF, 0x400, 0x800 on consecutive cycles.
  - Required: three consecutive `rvalidA_o` pulses with the correct data in order, proving the registered bank select.
- **Byte enables.** Write 0xFF…FF to 0x010, then write with `weA_i=0x00F0` and data 0.
  - Required: a read returns 0xFF…FF_0000_0000_FFFF_FFFF (bytes 4–7 zero).
- **Write-write collision.** In the same cycle, A writes 0xAA…AA to 0x123 with `we=0x00FF` and B writes 0xBB…BB to 0x123 with `we=0xFFFF`.
  - Required: `collision_o` pulses.
  - Required: a readback gives upper 8 bytes 0xBB and lower 8 bytes 0xAA.
- **Read-write collision.** 0x200 holds 0x11…11. In one cycle, A reads 0x200 and B writes 0x22…22 to it.
  - Required: A returns 0x11…11.
  - Required: a read the next cycle returns 0x22…22.
- **Reset mid-read.** Issue a read, then pulse `rst_ni` low before `rvalid`.
  - Required: all outputs go to 0 asynchronously, and no `rvalid` appears after release.
